// File: rtl/hdmi_pkg.sv
// Shared constants and types for the HDMI pixel filter output path.
package hdmi_pkg;

   localparam int PIX_W   = 8;
   localparam int P_W     = 48;
   localparam int PIX_MAX = 255;

   // Video sample carried alongside the filter: raw pixel plus syncs.
   typedef struct packed {
      logic [PIX_W-1:0] pix;
      logic             de;
      logic             hs;
      logic             vs;
   } vid_t;

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth register shift line with synchronous reset.
module sig_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] line [DEPTH];

   // Shift d through DEPTH registers; reset clears every stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) line[i] <= '0;
      end else begin
         line[0] <= d;
         for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
      end
   end

   assign q = line[DEPTH-1];

endmodule

// File: rtl/fir_out_rnd_sat.sv
// FIR output stage: round/rescale the 48-bit cascade result, clamp it to an
// 8-bit pixel, re-align video controls, frame-synchronous bypass and a
// per-frame saturated-pixel counter.
module fir_out_rnd_sat
   import hdmi_pkg::*;
#(
   parameter int FILT_LAT  = 4,
   parameter int FRAC_BITS = 16,
   parameter int CNT_W     = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PIX_W-1:0]   pix_in,
   input  logic               de_in,
   input  logic               hs_in,
   input  logic               vs_in,
   input  logic [P_W-1:0]     p,
   input  logic               bypass,
   output logic [PIX_W-1:0]   pix_out,
   output logic               de_out,
   output logic               hs_out,
   output logic               vs_out,
   output logic               sat_out,
   output logic [CNT_W-1:0]   sat_cnt
);

   // One extra bit so adding the rounding half can never overflow.
   localparam int S_W = P_W + 1;
   localparam logic signed [S_W-1:0] HALF = {{(S_W-1){1'b0}}, 1'b1} << (FRAC_BITS-1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   vid_t vid_in;
   vid_t vid_d;

   logic signed [S_W-1:0] s1;
   logic signed [S_W-1:0] q;
   logic [PIX_W-1:0]      pix_c;
   logic                  sat_c;
   logic [PIX_W-1:0]      pix_f;
   logic                  sat_f;

   logic                  bypass_act;
   logic                  vs_prev;
   logic                  vs_rise;
   logic                  cnt_inc;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_next;

   // Controls and raw pixel ride the filter latency plus the two rounding stages.
   assign vid_in = {pix_in, de_in, hs_in, vs_in};

   sig_delay #(
      .WIDTH ($bits(vid_t)),
      .DEPTH (FILT_LAT + 2)
   ) u_vid_dly (
      .clk (clk),
      .rst (rst),
      .d   (vid_in),
      .q   (vid_d)
   );

   // Stage 1: add half an LSB of the output scale (round half toward +inf).
   always_ff @(posedge clk) begin
      if (rst) s1 <= '0;
      else     s1 <= $signed({p[P_W-1], p}) + HALF;
   end

   // Rescale and clamp the rounded value to the pixel range.
   always_comb begin
      q     = s1 >>> FRAC_BITS;
      pix_c = q[PIX_W-1:0];
      sat_c = 1'b0;
      if (q[S_W-1]) begin
         pix_c = '0;
         sat_c = 1'b1;
      end else if (|q[S_W-2:PIX_W]) begin
         pix_c = PIX_W'(PIX_MAX);
         sat_c = 1'b1;
      end
   end

   // Stage 2: register the clamped pixel and its saturation flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_f <= '0;
         sat_f <= 1'b0;
      end else begin
         pix_f <= pix_c;
         sat_f <= sat_c;
      end
   end

   // Output selection; bypass never reports saturation.
   always_comb begin
      pix_out = bypass_act ? vid_d.pix : pix_f;
      sat_out = sat_f & ~bypass_act;
      de_out  = vid_d.de;
      hs_out  = vid_d.hs;
      vs_out  = vid_d.vs;
   end

   // Frame start is the rising edge of the aligned vsync.
   assign vs_rise = vid_d.vs & ~vs_prev;
   assign cnt_inc = de_out & sat_out;

   // Sticky increment: the counter holds at all-ones instead of wrapping.
   always_comb begin
      cnt_next = cnt;
      if (cnt_inc && (cnt != CNT_MAX)) cnt_next = cnt + 1'b1;
   end

   // Frame bookkeeping: latch bypass and publish the count on each frame start;
   // a saturated pixel on the edge cycle still belongs to the closing frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_prev    <= 1'b0;
         bypass_act <= 1'b0;
         cnt        <= '0;
         sat_cnt    <= '0;
      end else begin
         vs_prev <= vid_d.vs;
         if (vs_rise) begin
            sat_cnt    <= cnt_next;
            cnt        <= '0;
            bypass_act <= bypass;
         end else begin
            cnt <= cnt_next;
         end
      end
   end

endmodule

// File: tb/tb_fir_out_rnd_sat.sv
// Bench for fir_out_rnd_sat: per-cycle scoreboard of aligned outputs plus a
// small frame model for bypass selection and the saturation counter.
module tb_fir_out_rnd_sat;

   localparam int CNT_W = 4;
   localparam int EXP_W = 20;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic [7:0] raw;
      logic [7:0] fpix;
      logic       fsat;
      logic       de;
      logic       hs;
      logic       vs;
   } exp_t;

   logic              clk;
   logic              rst;
   logic [7:0]        pix_in;
   logic              de_in;
   logic              hs_in;
   logic              vs_in;
   logic [47:0]       p;
   logic              bypass;
   logic [7:0]        pix_out;
   logic              de_out;
   logic              hs_out;
   logic              vs_out;
   logic              sat_out;
   logic [CNT_W-1:0]  sat_cnt;

   logic [EXP_W-1:0]  exp_q[$];
   logic [47:0]       p_q[$];

   int                n_checks;
   int                n_fail;

   logic              byp_drv;
   logic              m_byp;
   logic              m_vs_prev;
   logic [CNT_W-1:0]  m_cnt;
   logic [CNT_W-1:0]  m_sat_cnt;

   fir_out_rnd_sat #(
      .FILT_LAT  (4),
      .FRAC_BITS (16),
      .CNT_W     (CNT_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .pix_in  (pix_in),
      .de_in   (de_in),
      .hs_in   (hs_in),
      .vs_in   (vs_in),
      .p       (p),
      .bypass  (bypass),
      .pix_out (pix_out),
      .de_out  (de_out),
      .hs_out  (hs_out),
      .vs_out  (vs_out),
      .sat_out (sat_out),
      .sat_cnt (sat_cnt)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference rounding: floor((p + 0.5) in output units), then clamp.
   task automatic ref_round(input logic [47:0] pv, output logic [7:0] pix, output logic sat);
      longint s;
      longint qv;
      s  = longint'($signed(pv));
      qv = (s + 64'sd32768) >>> 16;
      if (qv < 0) begin
         pix = 8'd0;   sat = 1'b1;
      end else if (qv > 255) begin
         pix = 8'd255; sat = 1'b1;
      end else begin
         pix = qv[7:0]; sat = 1'b0;
      end
   endtask

   // 0: in range, 1: above 255, 2: below zero, 3: exact half, 4: full random
   function automatic logic [47:0] make_p(input int kind);
      longint v;
      case (kind)
         0:       v = longint'($urandom_range(0, 254)) * 65536 + longint'($urandom_range(0, 65535));
         1:       v = longint'($urandom_range(256, 60000)) * 65536 + longint'($urandom_range(0, 65535));
         2:       v = -longint'($urandom_range(32769, 2000000000));
         3:       v = longint'($urandom_range(0, 255)) * 65536 + 32768;
         default: v = {longint'($urandom), 32'(longint'($urandom))};
      endcase
      return v[47:0];
   endfunction

   // One pixel cycle: compare this cycle's outputs, drive new inputs, advance model.
   task automatic step(input logic [7:0] pix, input logic de, input logic hs, input logic vs,
                       input logic [47:0] pv, input logic rs);
      exp_t             e;
      logic [7:0]       ep;
      logic             es;
      logic [7:0]       fp;
      logic             fs;
      logic             inc;
      logic             rise;
      logic [CNT_W-1:0] nxt;
      @(posedge clk);
      #1;
      e  = exp_t'(exp_q.pop_front());
      ep = m_byp ? e.raw : e.fpix;
      es = m_byp ? 1'b0 : e.fsat;
      check("pix_out", pix_out, ep);
      check("sat_out", sat_out, es);
      check("de_out",  de_out,  e.de);
      check("hs_out",  hs_out,  e.hs);
      check("vs_out",  vs_out,  e.vs);
      check("sat_cnt", sat_cnt, m_sat_cnt);

      rst    = rs;
      bypass = byp_drv;
      pix_in = pix;
      de_in  = de;
      hs_in  = hs;
      vs_in  = vs;
      ref_round(pv, fp, fs);
      exp_q.push_back({pix, fp, fs, de, hs, vs});
      p_q.push_back(pv);
      p = p_q.pop_front();

      if (rs) begin
         exp_q.delete();
         repeat (6) exp_q.push_back('0);
         p_q.delete();
         repeat (4) p_q.push_back('0);
         m_byp     = 1'b0;
         m_vs_prev = 1'b0;
         m_cnt     = '0;
         m_sat_cnt = '0;
      end else begin
         inc  = e.de & es;
         rise = e.vs & ~m_vs_prev;
         nxt  = (inc && (m_cnt != CNT_MAX)) ? m_cnt + 1'b1 : m_cnt;
         if (rise) begin
            m_sat_cnt = nxt;
            m_cnt     = '0;
            m_byp     = byp_drv;
         end else begin
            m_cnt = nxt;
         end
         m_vs_prev = e.vs;
      end
   endtask

   task automatic pixel(input int kind);
      step(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0, make_p(kind), 1'b0);
   endtask

   task automatic idle(input int n, input logic hs, input logic vs);
      repeat (n) step(8'($urandom_range(0, 255)), 1'b0, hs, vs, make_p(0), 1'b0);
   endtask

   task automatic line(input int len, input int sat_pct);
      int kind;
      idle(2, 1'b1, 1'b0);
      for (int i = 0; i < len; i++) begin
         if ($urandom_range(0, 99) < sat_pct) kind = int'($urandom_range(1, 2));
         else if ($urandom_range(0, 9) == 0)  kind = 4;
         else if ($urandom_range(0, 3) == 0)  kind = 3;
         else                                 kind = 0;
         pixel(kind);
      end
   endtask

   task automatic frame_start();
      idle(2, 1'b0, 1'b1);
      idle(1, 1'b0, 1'b0);
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      byp_drv   = 1'b0;
      m_byp     = 1'b0;
      m_vs_prev = 1'b0;
      m_cnt     = '0;
      m_sat_cnt = '0;
      rst       = 1'b1;
      bypass    = 1'b0;
      pix_in    = '0;
      de_in     = 1'b0;
      hs_in     = 1'b0;
      vs_in     = 1'b0;
      p         = '0;
      repeat (6) exp_q.push_back('0);
      repeat (4) p_q.push_back('0);

      // Reset held, outputs must read zero.
      step(8'h00, 1'b0, 1'b0, 1'b0, 48'h0, 1'b1);
      step(8'h00, 1'b0, 1'b0, 1'b0, 48'h0, 1'b0);

      // Rounding and clamp boundaries.
      step(8'h11, 1'b1, 1'b0, 1'b0, 48'h0000_0080_8000, 1'b0);  // 128.5 -> 129
      step(8'h22, 1'b1, 1'b0, 1'b0, 48'h0000_007F_7FFF, 1'b0);  // -> 127
      step(8'h33, 1'b1, 1'b0, 1'b0, 48'h0000_012C_0000, 1'b0);  // 300 -> 255 sat
      step(8'h44, 1'b1, 1'b0, 1'b0, 48'hFFFF_FFFB_0000, 1'b0);  // -5 -> 0 sat
      step(8'h55, 1'b1, 1'b0, 1'b0, 48'hFFFF_FFFF_FFFF, 1'b0);  // -1 lsb -> 0
      step(8'h66, 1'b1, 1'b0, 1'b0, 48'h0000_00FF_8000, 1'b0);  // 255.5 -> sat
      step(8'h77, 1'b1, 1'b0, 1'b0, 48'h0000_00FF_7FFF, 1'b0);  // -> 255
      step(8'h88, 1'b1, 1'b0, 1'b0, 48'hFFFF_FFFF_8000, 1'b0);  // -0.5 -> 0
      step(8'h99, 1'b1, 1'b0, 1'b0, 48'hFFFF_FFFF_7FFF, 1'b0);  // -> 0 sat
      step(8'hAA, 1'b0, 1'b1, 1'b1, 48'h0000_0001_0000, 1'b0);  // ctrl pulse
      idle(8, 1'b0, 1'b0);

      // Frame with exactly three saturated de pixels.
      frame_start();
      idle(2, 1'b1, 1'b0);
      pixel(1); pixel(0); pixel(2); pixel(0); pixel(1); pixel(0);
      idle(2, 1'b0, 1'b0);
      frame_start();
      idle(10, 1'b0, 1'b0);
      check("sat_cnt_three", sat_cnt, 4'd3);

      // Three more, plus one on the vsync edge cycle itself.
      idle(2, 1'b1, 1'b0);
      pixel(2); pixel(0); pixel(1); pixel(2);
      step(8'h5A, 1'b1, 1'b0, 1'b1, make_p(1), 1'b0);
      idle(1, 1'b0, 1'b1);
      idle(10, 1'b0, 1'b0);
      check("sat_cnt_edge", sat_cnt, 4'd4);

      // Counter must stick at all-ones.
      line(12, 100); line(12, 100); line(12, 100);
      frame_start();
      idle(10, 1'b0, 1'b0);
      check("sat_cnt_stick", sat_cnt, 4'd15);

      // Random frames.
      for (int f = 0; f < 3; f++) begin
         line(10, 30);
         line(10, 30);
         frame_start();
      end

      // Bypass requested mid-frame, active only from the next frame.
      line(10, 30);
      byp_drv = 1'b1;
      line(10, 30);
      frame_start();
      line(10, 40);
      byp_drv = 1'b0;
      line(10, 40);
      frame_start();
      line(10, 40);

      // Lines without a frame start: published count holds.
      line(10, 50);
      line(10, 50);

      // One-cycle reset in the middle of a line.
      idle(2, 1'b1, 1'b0);
      pixel(1); pixel(0); pixel(2);
      step(8'h3C, 1'b1, 1'b0, 1'b0, make_p(1), 1'b1);
      pixel(2);
      check("sat_cnt_after_rst", sat_cnt, 4'd0);
      pixel(1); pixel(0); pixel(3); pixel(1); pixel(2);
      line(10, 30);
      frame_start();
      line(10, 30);
      frame_start();
      idle(10, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
